// File: rtl/rq_gearbox256_pkg.sv
// Shared constants and helpers for the RQ gearbox.
//   DW_W / DESC_W / AXIS_W : dword, descriptor and stream widths
//   TUSER_W, FIRST_BE_LSB, LAST_BE_LSB, BE_W : s_axis_rq_tuser layout
//   ones(n) : keep mask with the n lowest dword bits set (n = 0..8)
package rq_gearbox256_pkg;

  localparam int unsigned DW_W         = 32;
  localparam int unsigned DESC_W       = 128;
  localparam int unsigned AXIS_W       = 256;
  localparam int unsigned KEEP_W       = AXIS_W / DW_W;
  localparam int unsigned TUSER_W      = 60;
  localparam int unsigned BE_W         = 4;
  localparam int unsigned FIRST_BE_LSB = 0;
  localparam int unsigned LAST_BE_LSB  = 4;
  localparam int unsigned CNT_W        = 11;
  localparam int unsigned NLAST_W      = 4;

  function automatic logic [KEEP_W-1:0] ones(input int unsigned n);
    logic [KEEP_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/rq_gearbox256.sv
// Packs user write-request beats into the 256-bit PCIe RQ AXI-Stream.
// The 128-bit descriptor fills DW0-3 of the first output beat, so payload is
// shifted up by four dwords; the upper half of each user beat is carried into
// the next output beat, and a trailing flush beat is emitted when the final
// user beat leaves more than four dwords behind.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   descriptor            : RQ descriptor, sampled on the sop beat
//   rq_wr_data            : payload beat, DW0 in [31:0]
//   rq_dword_count        : packet payload length in dwords, sampled on sop
//   rq_valid/rq_sop/rq_last/rq_ready : user-side handshake and framing
//   s_axis_rq_*           : registered AXI-Stream towards the hard IP
module rq_gearbox256
  import rq_gearbox256_pkg::*;
#(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [127:0]          descriptor,
  input  logic [DATA_WIDTH-1:0] rq_wr_data,
  input  logic [10:0]           rq_dword_count,
  input  logic                  rq_last,
  input  logic                  rq_valid,
  input  logic                  rq_sop,
  output logic                  rq_ready,
  output logic [DATA_WIDTH-1:0] s_axis_rq_tdata,
  output logic                  s_axis_rq_tvalid,
  output logic [59:0]           s_axis_rq_tuser,
  output logic [7:0]            s_axis_rq_tkeep,
  output logic                  s_axis_rq_tlast,
  input  logic                  s_axis_rq_tready
);

  logic [DATA_WIDTH-1:0] tdata_q,  tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic [TUSER_W-1:0]    tuser_q,  tuser_d;
  logic [KEEP_W-1:0]     tkeep_q,  tkeep_d;
  logic                  tlast_q,  tlast_d;
  logic [DESC_W-1:0]     carry_q,  carry_d;
  logic                  one_more_cycle_q, one_more_cycle_d;
  logic [NLAST_W-1:0]    n_last_q, n_last_d;

  logic                  load_en;
  logic                  accept;
  logic [2:0]            cnt_m1_lo;
  logic [NLAST_W-1:0]    sop_n_last;
  logic [NLAST_W-1:0]    cur_n_last;
  logic [DESC_W-1:0]     low_half;

  always_comb begin
    load_en  = !tvalid_q || s_axis_rq_tready;
    rq_ready = load_en && !one_more_cycle_q;
    accept   = rq_valid && rq_ready;

    // ((count-1) mod 8) + 1 only depends on the low three bits; 1024 wraps to 8.
    cnt_m1_lo  = rq_dword_count[2:0] - 3'd1;
    sop_n_last = {1'b0, cnt_m1_lo} + 4'd1;
    // A single-beat packet finishes on its sop beat, before n_last_q is loaded.
    cur_n_last = rq_sop ? sop_n_last : n_last_q;
    low_half   = rq_sop ? descriptor : carry_q;

    tdata_d          = tdata_q;
    tvalid_d         = tvalid_q;
    tuser_d          = tuser_q;
    tkeep_d          = tkeep_q;
    tlast_d          = tlast_q;
    carry_d          = carry_q;
    one_more_cycle_d = one_more_cycle_q;
    n_last_d         = n_last_q;

    if (accept && rq_sop) begin
      n_last_d = sop_n_last;
    end

    if (load_en) begin
      if (one_more_cycle_q) begin
        tdata_d          = {{(DATA_WIDTH-DESC_W){1'b0}}, carry_q};
        tkeep_d          = ones(32'(n_last_q) - 32'd4);
        tlast_d          = 1'b1;
        tuser_d          = '0;
        tvalid_d         = 1'b1;
        one_more_cycle_d = 1'b0;
      end else if (accept) begin
        tdata_d  = {rq_wr_data[DESC_W-1:0], low_half};
        carry_d  = rq_wr_data[DATA_WIDTH-1:DESC_W];
        tvalid_d = 1'b1;
        tuser_d  = '0;
        if (rq_sop) begin
          tuser_d[FIRST_BE_LSB +: BE_W] = '1;
          tuser_d[LAST_BE_LSB +: BE_W]  = (rq_dword_count > 11'd1) ? 4'hF : 4'h0;
        end
        tkeep_d = '1;
        tlast_d = 1'b0;
        if (rq_last) begin
          if (cur_n_last <= 4'd4) begin
            tkeep_d = ones(32'(cur_n_last) + 32'd4);
            tlast_d = 1'b1;
          end else begin
            one_more_cycle_d = 1'b1;
          end
        end
      end else begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_q          <= '0;
      tvalid_q         <= 1'b0;
      tuser_q          <= '0;
      tkeep_q          <= '0;
      tlast_q          <= 1'b0;
      carry_q          <= '0;
      one_more_cycle_q <= 1'b0;
      n_last_q         <= '0;
    end else begin
      tdata_q          <= tdata_d;
      tvalid_q         <= tvalid_d;
      tuser_q          <= tuser_d;
      tkeep_q          <= tkeep_d;
      tlast_q          <= tlast_d;
      carry_q          <= carry_d;
      one_more_cycle_q <= one_more_cycle_d;
      n_last_q         <= n_last_d;
    end
  end

  assign s_axis_rq_tdata  = tdata_q;
  assign s_axis_rq_tvalid = tvalid_q;
  assign s_axis_rq_tuser  = tuser_q;
  assign s_axis_rq_tkeep  = tkeep_q;
  assign s_axis_rq_tlast  = tlast_q;

endmodule

// File: tb/tb_rq_gearbox256.sv
// Self-checking bench for rq_gearbox256: a packet-level reference model builds
// the expected output stream (descriptor dwords followed by payload dwords,
// cut into 8-dword beats) and a monitor compares every accepted output beat.
module tb_rq_gearbox256;

  typedef struct {
    logic [255:0] data;
    logic [7:0]   keep;
    logic         last;
    logic [59:0]  user;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] descriptor = '0;
  logic [255:0] rq_wr_data = '0;
  logic [10:0]  rq_dword_count = '0;
  logic         rq_last = 1'b0;
  logic         rq_valid = 1'b0;
  logic         rq_sop = 1'b0;
  logic         rq_ready;
  logic [255:0] s_axis_rq_tdata;
  logic         s_axis_rq_tvalid;
  logic [59:0]  s_axis_rq_tuser;
  logic [7:0]   s_axis_rq_tkeep;
  logic         s_axis_rq_tlast;
  logic         s_axis_rq_tready = 1'b1;

  int checks = 0;
  int errors = 0;
  int tready_mode = 0;   // 0: always 1, 1: toggle, 2: random
  beat_t exp_q[$];

  rq_gearbox256 #(.DATA_WIDTH(256)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .descriptor       (descriptor),
    .rq_wr_data       (rq_wr_data),
    .rq_dword_count   (rq_dword_count),
    .rq_last          (rq_last),
    .rq_valid         (rq_valid),
    .rq_sop           (rq_sop),
    .rq_ready         (rq_ready),
    .s_axis_rq_tdata  (s_axis_rq_tdata),
    .s_axis_rq_tvalid (s_axis_rq_tvalid),
    .s_axis_rq_tuser  (s_axis_rq_tuser),
    .s_axis_rq_tkeep  (s_axis_rq_tkeep),
    .s_axis_rq_tlast  (s_axis_rq_tlast),
    .s_axis_rq_tready (s_axis_rq_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // tready driven at negedge+1 so it is stable across the sampling point.
  always begin
    @(negedge clk);
    #1;
    case (tready_mode)
      0:       s_axis_rq_tready = 1'b1;
      1:       s_axis_rq_tready = ~s_axis_rq_tready;
      default: s_axis_rq_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: samples two time units before each rising edge.
  logic         prev_stall = 1'b0;
  logic [255:0] prev_data;
  logic [7:0]   prev_keep;
  logic         prev_last;
  logic [59:0]  prev_user;

  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_tvalid", 256'(s_axis_rq_tvalid), 256'd1);
        chk("hold_tdata", s_axis_rq_tdata, prev_data);
        chk("hold_tkeep", 256'(s_axis_rq_tkeep), 256'(prev_keep));
        chk("hold_tlast", 256'(s_axis_rq_tlast), 256'(prev_last));
        chk("hold_tuser", 256'(s_axis_rq_tuser), 256'(prev_user));
      end
      if (s_axis_rq_tvalid && s_axis_rq_tready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat: observed tdata %h with no beat expected", s_axis_rq_tdata);
        end
        if (exp_q.size() != 0) begin
          beat_t e;
          logic [255:0] mask;
          e = exp_q.pop_front();
          for (int j = 0; j < 8; j++) mask[32*j +: 32] = {32{e.keep[j]}};
          chk("beat_tkeep", 256'(s_axis_rq_tkeep), 256'(e.keep));
          chk("beat_tlast", 256'(s_axis_rq_tlast), 256'(e.last));
          chk("beat_tuser", 256'(s_axis_rq_tuser), 256'(e.user));
          chk("beat_tdata", s_axis_rq_tdata & mask, e.data);
        end
      end
      prev_stall = s_axis_rq_tvalid && !s_axis_rq_tready;
      prev_data  = s_axis_rq_tdata;
      prev_keep  = s_axis_rq_tkeep;
      prev_last  = s_axis_rq_tlast;
      prev_user  = s_axis_rq_tuser;
    end
  end

  // Entered at negedge+1; returns at negedge+1 after the accepting edge.
  task automatic drive_beat(input logic [127:0] desc, input logic [255:0] wd,
                            input logic [10:0] cnt, input logic sop, input logic last);
    int  guard;
    logic ok;
    descriptor     = desc;
    rq_wr_data     = wd;
    rq_dword_count = cnt;
    rq_sop         = sop;
    rq_last        = last;
    rq_valid       = 1'b1;
    guard          = 0;
    forever begin
      #3;
      ok = rq_ready;
      @(posedge clk);
      @(negedge clk);
      #1;
      if (ok) break;
      guard++;
      if (guard > 500) begin
        chk("accept_timeout", 256'd0, 256'd1);
        break;
      end
    end
    rq_valid = 1'b0;
  endtask

  // Builds the expected beats from the packet contents, then drives it.
  task automatic send_packet(input int dw, input logic [127:0] desc, input bit dead);
    logic [31:0] words[$];
    logic [31:0] stream[$];
    int total, nb, ub;
    words = {};
    for (int i = 0; i < dw; i++) words.push_back(dead ? 32'hDEAD0000 + 32'(i + 1) : $urandom);
    stream = {};
    for (int i = 0; i < 4; i++) stream.push_back(desc[32*i +: 32]);
    for (int i = 0; i < dw; i++) stream.push_back(words[i]);
    total = 4 + dw;
    nb = (total + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      beat_t e;
      e.data = '0;
      e.keep = '0;
      for (int j = 0; j < 8; j++) begin
        if (8*b + j < total) begin
          e.data[32*j +: 32] = stream[8*b + j];
          e.keep[j] = 1'b1;
        end
      end
      e.last = (b == nb - 1);
      e.user = '0;
      if (b == 0) e.user[7:0] = (dw > 1) ? 8'hFF : 8'h0F;
      exp_q.push_back(e);
    end
    ub = (dw + 7) / 8;
    for (int u = 0; u < ub; u++) begin
      logic [255:0] wd;
      for (int j = 0; j < 8; j++) wd[32*j +: 32] = (8*u + j < dw) ? words[8*u + j] : $urandom;
      drive_beat((u == 0) ? desc : {$urandom, $urandom, $urandom, $urandom}, wd,
                 (u == 0) ? 11'(dw) : 11'($urandom), u == 0, u == ub - 1);
    end
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    #1;
    chk(tag, 256'(exp_q.size()), 256'd0);
  endtask

  function automatic logic [127:0] rand_desc();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    // Reset state
    #2;
    chk("rst_tvalid", 256'(s_axis_rq_tvalid), 256'd0);
    chk("rst_tlast", 256'(s_axis_rq_tlast), 256'd0);
    chk("rst_tdata", s_axis_rq_tdata, 256'd0);
    chk("rst_tkeep", 256'(s_axis_rq_tkeep), 256'd0);
    chk("rst_tuser", 256'(s_axis_rq_tuser), 256'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("idle_rq_ready", 256'(rq_ready), 256'd1);
    @(negedge clk);
    #1;

    // Directed single-beat lengths and the multi-beat cases
    tready_mode = 0;
    send_packet(1, rand_desc(), 1'b1);
    drain("drain_dw1");
    send_packet(2, rand_desc(), 1'b1);
    send_packet(4, rand_desc(), 1'b1);
    drain("drain_dw2_dw4");

    send_packet(7, rand_desc(), 1'b1);
    chk("dw7_ready_during_flush", 256'(rq_ready), 256'd0);
    @(negedge clk);
    #1;
    chk("dw7_ready_after_flush", 256'(rq_ready), 256'd1);
    drain("drain_dw7");

    send_packet(9, rand_desc(), 1'b1);
    drain("drain_dw9");

    tready_mode = 1;
    send_packet(8, rand_desc(), 1'b1);
    drain("drain_dw8_toggle");

    tready_mode = 2;
    send_packet(1024, rand_desc(), 1'b0);
    drain("drain_dw1024");

    // Randomized packets and backpressure
    for (int p = 0; p < 30; p++) begin
      tready_mode = int'($urandom_range(0, 2));
      send_packet(int'($urandom_range(1, 48)), rand_desc(), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #1;
      end
    end
    drain("drain_random");

    // Reset while the flush beat is pending
    tready_mode = 0;
    repeat (2) @(negedge clk);
    #1;
    send_packet(7, rand_desc(), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", 256'(s_axis_rq_tvalid), 256'd0);
    chk("midrst_tkeep", 256'(s_axis_rq_tkeep), 256'd0);
    chk("midrst_tlast", 256'(s_axis_rq_tlast), 256'd0);
    exp_q = {};
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_ready", 256'(rq_ready), 256'd1);
    send_packet(1, rand_desc(), 1'b1);
    drain("drain_post_rst");

    // tvalid drops once nothing is left to send
    repeat (2) @(negedge clk);
    #1;
    chk("idle_tvalid", 256'(s_axis_rq_tvalid), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
